// File: rtl/n_bit_mdu.sv
// rtl/n_bit_mdu.sv - iterative RISC-V M-extension multiply/divide unit
// Shift-add multiply and restoring divide share one accumulator, one operand register and one counter.
module n_bit_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               neg;
  logic [2:0]         op;

  logic               a_signed;
  logic               b_signed;
  logic               neg_in;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               div_zero;
  logic               div_ovf;
  logic               special;
  logic [2*WIDTH-1:0] special_acc;
  logic [2*WIDTH-1:0] load_acc;
  logic [WIDTH-1:0]   load_opnd;

  // Operand conditioning at accept: signed operands become magnitudes, the sign goes to neg.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    neg_in   = 1'b0;
    case (funct3)
      OP_MULH, OP_DIV: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
        neg_in   = a[WIDTH-1] ^ b[WIDTH-1];
      end
      OP_MULHSU: begin
        a_signed = 1'b1;
        neg_in   = a[WIDTH-1];
      end
      OP_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
        neg_in   = a[WIDTH-1];
      end
      default: begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        neg_in   = 1'b0;
      end
    endcase
  end

  assign a_mag = (a_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (b_signed && b[WIDTH-1]) ? -b : b;

  assign div_zero = (b == '0);
  assign div_ovf  = (a == MOST_NEG) && (b == '1) && !funct3[0];
  assign special  = funct3[2] && (div_zero || div_ovf);

  // Special results are parked in the accumulator halves that FIX reads, with neg cleared.
  always_comb begin
    special_acc = '0;
    if (div_zero) begin
      if (funct3[1]) special_acc = {a, {WIDTH{1'b0}}};
      else           special_acc = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
    end else if (!funct3[1]) begin
      special_acc = {{WIDTH{1'b0}}, a};
    end
  end

  always_comb begin
    load_acc  = '0;
    load_opnd = '0;
    if (funct3[2]) begin
      load_acc  = {{WIDTH{1'b0}}, a_mag};
      load_opnd = b_mag;
    end else begin
      load_acc  = {{WIDTH{1'b0}}, b_mag};
      load_opnd = a_mag;
    end
  end

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;

  // Multiply: high half accumulates the multiplicand, low half shifts the multiplier out.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide: high half is the partial remainder, low half trades dividend bits for quotient bits.
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd};
  assign div_next  = div_diff[WIDTH+1] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_result;

  assign prod_fix = neg ? -acc : acc;
  assign quo      = acc[WIDTH-1:0];
  assign rem      = acc[2*WIDTH-1:WIDTH];
  assign quo_fix  = neg ? -quo : quo;
  assign rem_fix  = neg ? -rem : rem;

  always_comb begin
    fix_result = '0;
    if (op[2]) fix_result = op[1] ? rem_fix : quo_fix;
    else if (op == OP_MUL) fix_result = prod_fix[WIDTH-1:0];
    else fix_result = prod_fix[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      count  <= '0;
      acc    <= '0;
      opnd   <= '0;
      neg    <= 1'b0;
      op     <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              op   <= funct3;
              busy <= 1'b1;
              if (special) begin
                acc   <= special_acc;
                neg   <= 1'b0;
                state <= FIX;
              end else begin
                acc   <= load_acc;
                opnd  <= load_opnd;
                neg   <= neg_in;
                count <= CNT_INIT;
                state <= CALC;
              end
            end
          end
          CALC: begin
            acc   <= op[2] ? div_next : mul_next;
            count <= count - 1'b1;
            if (count == CNT_ONE) state <= FIX;
          end
          FIX: begin
            result <= fix_result;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/n_bit_mdu.md
# n_bit_mdu

Parametrised iterative multiply/divide unit implementing the RISC-V M-extension operations on WIDTH-bit operands. It sits beside the combinational ALU in the execute stage. The pipeline stalls on `busy` while a MUL/DIV instruction iterates and consumes `result` when `done` pulses. Radix-2 shift-add multiplication and restoring division share one datapath and one counter. Divide-by-zero and signed overflow complete on a fast path.

## Interface
- WIDTH, 32: operand/result width; must be ≥ 4 and even.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  request; accepted only at an edge where `busy`=0 and `flush`=0.
- funct3  in  3  op select:
  - 000 MUL
  - 001 MULH
  - 010 MULHSU
  - 011 MULHU
  - 100 DIV
  - 101 DIVU
  - 110 REM
  - 111 REMU
- a, b  in  WIDTH  rs1, rs2 operands; sampled only at the accepting edge.
- flush  in  1  pipeline kill; aborts any operation in progress.
- busy  out  1  high from accepting edge until completion or abort.
- done  out  1  one-cycle pulse; `result` is valid in that cycle.
- result  out  WIDTH  last completed result; held until the next completion.

## Operation
- State machine IDLE, CALC, FIX.
  - IDLE: start accepted.
    - Special case → FIX directly.
    - Otherwise → CALC with count = WIDTH.
  - CALC: one iteration per edge; count decrements; at count = 1 → FIX.
  - FIX: sign correction applied, `result` registered, `done`=1 for the following cycle, → IDLE.
- Operand conditioning at accept:
  - Signed operands (a for MULH/MULHSU/DIV/REM, b for MULH/DIV/REM) are converted to magnitude.
  - Result-negate flag recorded:
    - MUL*: sign(a) XOR sign(b), over signed operands only.
    - DIV: sign(a) XOR sign(b).
    - REM: sign(a).
- Multiply: 2·WIDTH-bit product register. Each iteration adds the multiplicand if multiplier LSB = 1, then shifts right.
  - MUL returns the low WIDTH bits of the signed-corrected product.
  - MULH/MULHSU/MULHU return the high WIDTH bits.
  - MUL treats both operands as unsigned; the low half is sign-agnostic.
- Divide: restoring. Each iteration shifts the remainder left, subtracts the divisor, restores on borrow, and shifts in the quotient bit.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
  - Negation is applied in FIX.
- Special cases, detected at accept, bypass CALC:
  - b = 0, DIV/DIVU: result = all-ones. REM/REMU: result = a.
  - DIV with a = most-negative and b = all-ones: result = a. REM with the same operands: result = 0.
- All arithmetic is modulo 2^WIDTH at the output; internal accumulators are WIDTH+1 (div) or 2·WIDTH (mul) bits.

## Timing
- Reset (async, immediate): state IDLE, busy=0, done=0, result=0, count=0.
- Normal latency: accept at edge E0.
  - CALC occupies E1..E_WIDTH; FIX edge is E_{WIDTH+1}.
  - `done` is high in the cycle after E_{WIDTH+1}; `busy` is low in that same cycle.
  - Back-to-back: a new `start` may be accepted in the `done` cycle.
- Special-case latency: accept at E0, FIX at E1, `done` high in the cycle after E1.
- `busy` is registered and is 1 in every cycle between accept and FIX.
- `start` while busy=1 is ignored; no queueing.
- `flush`=1 at any edge:
  - State → IDLE, busy=0, no `done`, `result` unchanged.
  - `start` at the same edge is ignored.
  - `flush` in the `done` cycle does not retract the already-issued pulse.
- `rst` mid-operation aborts immediately; no `done` is produced.
- a, b and funct3 may change freely after the accepting edge without effect.

## Test plan
- **MUL/MULH:** WIDTH=32, a=0xFFFFFFFF (−1), b=0x00000002.
  - MUL → result 0xFFFFFFFE, done 33 cycles after accept.
  - MULH → 0xFFFFFFFF.
  - MULHU → 0x00000001.
  - MULHSU → 0xFFFFFFFF.
- **Signed divide:** a=−7 (0xFFFFFFF9), b=2.
  - DIV → 0xFFFFFFFD (−3).
  - REM → 0xFFFFFFFF (−1).
  - DIVU → 0x7FFFFFFC.
  - REMU → 0x00000001.
- **Divide by zero and overflow:**
  - a=0x12345678, b=0: DIV → 0xFFFFFFFF and REMU → 0x12345678, each with done 1 cycle after accept.
  - a=0x80000000, b=0xFFFFFFFF: DIV → 0x80000000 and REM → 0, 1-cycle latency.
- **Flush:** start MUL, assert `flush` at iteration 10.
  - busy drops next cycle, no done, result keeps its previous value.
  - A start issued together with `flush` is not accepted.
- **Back-to-back and ignored start:**
  - `start` held high for 40 cycles with changing operands → exactly one result per accept.
  - The second accept is in the done cycle; starts during busy are ignored.
- **Reset and parametrisation:**
  - `rst` asserted mid-CALC → busy, done and result go to 0 without waiting for an edge.
  - Repeat the MUL and DIV cases at WIDTH=8: a=−7, b=2 → DIV 0xFD, REM 0xFF, latency 9 cycles.
